// File: rtl/paddle_pkg.sv
// Shared types and default constants for the AY-3-8500 paddle emulator.
package paddle_pkg;

   localparam int unsigned PADDLE_POS_BITS    = 8;
   localparam int unsigned PADDLE_POS_CENTER  = 128;
   localparam int unsigned PADDLE_STEP        = 3;
   localparam int unsigned PADDLE_LINE_OFFSET = 24;
   localparam int unsigned PADDLE_POS_SHIFT   = 1;
   localparam int unsigned PADDLE_CNT_BITS    = 9;

   typedef enum logic [1:0] {
      DISCHARGE = 2'd0,
      RAMP      = 2'd1,
      TRIPPED   = 2'd2
   } state_t;

endpackage

// File: rtl/paddle_emu_if.sv
// Control, sync and comparator signals between the chip side and one paddle emulator.
interface paddle_emu_if
   import paddle_pkg::*;
#(
   parameter int unsigned POS_BITS = PADDLE_POS_BITS
);
   logic                btn_up;
   logic                btn_down;
   logic                hsync;
   logic                vsync;
   logic                dwn;
   logic                pin_out;
   logic [POS_BITS-1:0] position;

   modport master (
      output btn_up, btn_down, hsync, vsync, dwn,
      input  pin_out, position
   );

   modport slave (
      input  btn_up, btn_down, hsync, vsync, dwn,
      output pin_out, position
   );
endinterface

// File: rtl/rise_detect.sv
// Registered rising-edge detector: one-clk pulse one clk after din goes high.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic rise
);
   logic prev_q, prev_d;
   logic rise_q, rise_d;

   always_comb begin
      prev_d = din;
      rise_d = din & ~prev_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;
endmodule

// File: rtl/paddle_emu.sv
// One paddle: frame-rate saturating position plus RC-charge trip timing counted in scanlines.
module paddle_emu
   import paddle_pkg::*;
#(
   parameter int unsigned POS_BITS    = PADDLE_POS_BITS,
   parameter int unsigned POS_CENTER  = PADDLE_POS_CENTER,
   parameter int unsigned STEP        = PADDLE_STEP,
   parameter int unsigned LINE_OFFSET = PADDLE_LINE_OFFSET,
   parameter int unsigned POS_SHIFT   = PADDLE_POS_SHIFT,
   parameter int unsigned CNT_BITS    = PADDLE_CNT_BITS
) (
   input logic         clk,
   input logic         reset,
   paddle_emu_if.slave bus
);
   localparam logic [POS_BITS-1:0] POS_RST = POS_BITS'(POS_CENTER);
   localparam logic [POS_BITS-1:0] POS_MAX = {POS_BITS{1'b1}};
   localparam logic [POS_BITS:0]   STEP_X  = (POS_BITS+1)'(STEP);
   localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_OFS = CNT_BITS'(LINE_OFFSET);

   state_t              state_q, state_d;
   logic [POS_BITS-1:0] position_q, position_d;
   logic [POS_BITS-1:0] snapshot_q, snapshot_d;
   logic [CNT_BITS-1:0] line_cnt_q, line_cnt_d;
   logic                pin_out_q, pin_out_d;

   logic                hs_rise, vs_rise;
   logic [POS_BITS:0]   pos_dec, pos_inc;
   logic [CNT_BITS-1:0] thr, cnt_inc;

   rise_detect u_hs_rise (.clk(clk), .reset(reset), .din(bus.hsync), .rise(hs_rise));
   rise_detect u_vs_rise (.clk(clk), .reset(reset), .din(bus.vsync), .rise(vs_rise));

   // Once-per-frame saturating move; one extra bit catches borrow/carry.
   always_comb begin
      pos_dec    = {1'b0, position_q} - STEP_X;
      pos_inc    = {1'b0, position_q} + STEP_X;
      position_d = position_q;
      if (vs_rise && bus.btn_up && !bus.btn_down) begin
         position_d = pos_dec[POS_BITS] ? '0 : pos_dec[POS_BITS-1:0];
      end else if (vs_rise && bus.btn_down && !bus.btn_up) begin
         position_d = pos_inc[POS_BITS] ? POS_MAX : pos_inc[POS_BITS-1:0];
      end
   end

   always_comb begin
      thr     = CNT_OFS + CNT_BITS'(snapshot_q >> POS_SHIFT);
      cnt_inc = (line_cnt_q == CNT_MAX) ? line_cnt_q : line_cnt_q + CNT_BITS'(1);
   end

   // State register and datapath flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= DISCHARGE;
         position_q <= POS_RST;
         snapshot_q <= POS_RST;
         line_cnt_q <= '0;
         pin_out_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         position_q <= position_d;
         snapshot_q <= snapshot_d;
         line_cnt_q <= line_cnt_d;
         pin_out_q  <= pin_out_d;
      end
   end

   // Next state: dwn always wins over a same-cycle hsync rise.
   always_comb begin
      state_d = state_q;
      case (state_q)
         DISCHARGE: if (!bus.dwn) state_d = RAMP;
         RAMP: begin
            if (bus.dwn)                          state_d = DISCHARGE;
            else if (hs_rise && (cnt_inc >= thr)) state_d = TRIPPED;
         end
         TRIPPED:   if (bus.dwn) state_d = DISCHARGE;
         default:   state_d = DISCHARGE;
      endcase
   end

   // Outputs: snapshot is taken on entry to RAMP and held for the whole ramp.
   always_comb begin
      pin_out_d  = (state_d == TRIPPED);
      line_cnt_d = line_cnt_q;
      snapshot_d = snapshot_q;
      if (state_q == DISCHARGE && !bus.dwn) snapshot_d = position_q;
      if (state_d == DISCHARGE) begin
         line_cnt_d = '0;
      end else if (state_q == RAMP && hs_rise) begin
         line_cnt_d = cnt_inc;
      end
   end

   assign bus.pin_out  = pin_out_q;
   assign bus.position = position_q;
endmodule
